// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and helpers for the oversampled UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;

    // Minimum of one bit so a divide-by-one counter still has a legal width.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module : uart_baud_tick
// Brief  : Sample-tick divider, held at zero while clear is asserted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int c_W = div_width(DIV);
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

    assign tick = (r_cnt == c_LAST) && !clear;

endmodule

`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
// ============================================================================
// Module : uart_rx_oversampled
// Brief  : 8N1 UART receiver with oversampling, 3-sample majority vote,
//          start-glitch rejection and framing-error detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int c_SCW = $clog2(OVERSAMPLE);
    localparam int c_BIW = $clog2(DATA_BITS);

    localparam logic [c_SCW-1:0] c_VOTE_LO  = c_SCW'(OVERSAMPLE / 2 - 2);
    localparam logic [c_SCW-1:0] c_VOTE_MID = c_SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SCW-1:0] c_VOTE_HI  = c_SCW'(OVERSAMPLE / 2);
    localparam logic [c_SCW-1:0] c_SC_LAST  = c_SCW'(OVERSAMPLE - 1);
    localparam logic [c_BIW-1:0] c_BIT_LAST = c_BIW'(DATA_BITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_rxs;
    logic                 w_tick;
    logic [c_SCW-1:0]     r_sc;
    logic [c_BIW-1:0]     r_bit_idx;
    logic                 r_vote0;
    logic                 r_vote1;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_out;
    logic                 r_rdy;
    logic                 r_ferr;
    logic                 w_vote_tick;
    logic                 w_wrap;
    logic                 w_maj;
    logic                 w_good;
    logic                 w_bad;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == IDLE),
        .tick  (w_tick)
    );

    // Third vote is the live synchronized sample at the last vote tick.
    assign w_vote_tick = w_tick && (r_sc == c_VOTE_HI);
    assign w_wrap      = w_tick && (r_sc == c_SC_LAST);
    assign w_maj       = (r_vote0 & r_vote1) | (r_vote0 & r_rxs) | (r_vote1 & r_rxs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!r_rxs) w_state_nxt = START;
            end
            START: begin
                if (w_vote_tick && w_maj) w_state_nxt = IDLE;
                else if (w_wrap)          w_state_nxt = DATA;
            end
            DATA: begin
                if (w_wrap && (r_bit_idx == c_BIT_LAST)) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_vote_tick) begin
                    if (w_maj) begin
                        w_good      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (r_rxs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc      <= '0;
            r_bit_idx <= '0;
            r_vote0   <= 1'b0;
            r_vote1   <= 1'b0;
            r_shift   <= '0;
            r_out     <= '0;
            r_rdy     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rdy  <= w_good;
            r_ferr <= w_bad;
            if (w_good) r_out <= r_shift;

            if (r_state == IDLE) begin
                r_sc      <= '0;
                r_bit_idx <= '0;
                r_vote0   <= 1'b0;
                r_vote1   <= 1'b0;
            end else if (w_tick) begin
                r_sc <= (r_sc == c_SC_LAST) ? '0 : r_sc + c_SCW'(1);
                if (r_sc == c_VOTE_LO)  r_vote0 <= r_rxs;
                if (r_sc == c_VOTE_MID) r_vote1 <= r_rxs;
                // LSB-first: each new bit enters at the top and shifts down.
                if ((r_state == DATA) && (r_sc == c_VOTE_HI))
                    r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                if ((r_state == DATA) && (r_sc == c_SC_LAST))
                    r_bit_idx <= r_bit_idx + c_BIW'(1);
            end
        end
    end

    assign out       = r_out;
    assign rdy       = r_rdy;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
// ============================================================================
// Module : tb_uart_rx_oversampled
// Brief  : Self-checking bench with a sample-timeline reference model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_oversampled;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int OS     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] out;
    logic       rdy;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_rx_oversampled #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .out       (out),
        .rdy       (rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: frame timeline measured from the first low sample
    // of the synchronized line; bit b, sample k lands rel = 16*b + k later.
    typedef enum int {M_IDLE, M_FRAME, M_BREAK} mmode_t;
    mmode_t     mmode    = M_IDLE;
    bit         model_on = 0;
    int         cyc      = 0;
    int         t0       = 0;
    logic       h1 = 1'b1, h2 = 1'b1;
    logic [2:0] smp;
    logic [7:0] mdata;
    logic [7:0] exp_out  = 8'h00;
    logic       exp_rdy  = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_busy = 1'b0;

    int         rdy_cnt  = 0;
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) begin
        logic s;
        logic maj;
        int   rel, bitn, k;
        cyc++;
        exp_rdy  = 1'b0;
        exp_ferr = 1'b0;
        if (rst) begin
            model_on = 1;
            mmode    = M_IDLE;
            h1       = 1'b1;
            h2       = 1'b1;
            exp_out  = 8'h00;
        end else if (model_on) begin
            s  = h2;
            h2 = h1;
            h1 = rx;
            case (mmode)
                M_IDLE: if (!s) begin mmode = M_FRAME; t0 = cyc; end
                M_FRAME: begin
                    rel  = cyc - t0 - 1;
                    bitn = rel / OS;
                    k    = rel % OS;
                    if (k >= OS/2 - 2 && k <= OS/2) smp[k - (OS/2 - 2)] = s;
                    if (k == OS/2) begin
                        maj = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
                        if (bitn == 0) begin
                            if (maj) mmode = M_IDLE;
                        end else if (bitn <= 8) begin
                            mdata[bitn-1] = maj;
                        end else if (maj) begin
                            exp_out = mdata;
                            exp_rdy = 1'b1;
                            mmode   = M_IDLE;
                        end else begin
                            exp_ferr = 1'b1;
                            mmode    = M_BREAK;
                        end
                    end
                end
                M_BREAK: if (s) mmode = M_IDLE;
                default: mmode = M_IDLE;
            endcase
        end
        exp_busy = (mmode != M_IDLE);
        #1;
        if (model_on) begin
            chk("rdy", rdy, exp_rdy);
            chk("frame_err", frame_err, exp_ferr);
            chk("busy", busy, exp_busy);
            chk("out", out, exp_out);
            if (rdy) begin rdy_cnt++; got_q.push_back(out); end
            if (frame_err) ferr_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stopb, input int spike_bit, input int spike_pos);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int p = 0; p < OS; p++) begin
                rx = f[b] ^ ((b == spike_bit) && (p == spike_pos));
                @(negedge clk);
            end
        end
    endtask

    task automatic clear_counts();
        rdy_cnt  = 0;
        ferr_cnt = 0;
        busy_cnt = 0;
        got_q.delete();
    endtask

    function automatic logic [7:0] got(input int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        int r;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out", out, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rdy", rdy, 1'b0);
        hold(1'b1, 5);

        // Single clean frame
        clear_counts();
        send(8'hA5, 1'b1, -1, 0);
        hold(1'b1, 30);
        chkn("a5_rdy_count", rdy_cnt, 1);
        chkn("a5_ferr_count", ferr_cnt, 0);
        chk("a5_value", got(0), 8'hA5);
        chk("a5_model_pin", exp_out, 8'hA5);
        chk("a5_busy_idle", busy, 1'b0);

        // Start-bit glitch: 4 clk low
        clear_counts();
        hold(1'b0, 4);
        hold(1'b1, 20);
        chkn("glitch_rdy", rdy_cnt, 0);
        chkn("glitch_ferr", ferr_cnt, 0);
        chkn("glitch_busy_cycles", busy_cnt, 9);

        // Framing error then held-low break, then recovery
        clear_counts();
        send(8'h3C, 1'b0, -1, 0);
        hold(1'b0, 40);
        hold(1'b1, 30);
        chkn("brk_ferr_count", ferr_cnt, 1);
        chkn("brk_rdy_count", rdy_cnt, 0);
        chk("brk_out_held", out, 8'hA5);
        clear_counts();
        send(8'h5A, 1'b1, -1, 0);
        hold(1'b1, 30);
        chkn("5a_rdy_count", rdy_cnt, 1);
        chk("5a_value", got(0), 8'h5A);

        // Back-to-back frames, no gap
        clear_counts();
        send(8'h00, 1'b1, -1, 0);
        send(8'hFF, 1'b1, -1, 0);
        hold(1'b1, 30);
        chkn("b2b_rdy_count", rdy_cnt, 2);
        chkn("b2b_ferr_count", ferr_cnt, 0);
        chk("b2b_first", got(0), 8'h00);
        chk("b2b_second", got(1), 8'hFF);

        // Spike on the middle vote of data bit 3
        clear_counts();
        send(8'h0F, 1'b1, 4, 8);
        hold(1'b1, 30);
        chkn("spike_rdy_count", rdy_cnt, 1);
        chk("spike_value", got(0), 8'h0F);
        chk("spike_model_pin", exp_out, 8'h0F);

        // Reset during data bit 4
        clear_counts();
        f = {1'b1, 8'h81, 1'b0};
        for (int b = 0; b < 6; b++) begin
            for (int p = 0; p < OS; p++) begin
                if (b == 5 && p == 6) break;
                rx = f[b];
                @(negedge clk);
            end
        end
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out", out, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rdy", rdy, 1'b0);
        chk("midrst_ferr", frame_err, 1'b0);
        hold(1'b1, 20);
        chkn("midrst_no_strobe", rdy_cnt + ferr_cnt, 0);
        send(8'h81, 1'b1, -1, 0);
        hold(1'b1, 30);
        chkn("81_rdy_count", rdy_cnt, 1);
        chk("81_value", got(0), 8'h81);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, 16);
            end else if (r == 1) begin
                send(8'($urandom), 1'b0, -1, 0);
                hold(1'b0, $urandom_range(0, 30));
                hold(1'b1, $urandom_range(1, 20));
            end else if (r == 2) begin
                send(8'($urandom), 1'b1, $urandom_range(0, 9), $urandom_range(0, 15));
            end else begin
                send(8'($urandom), 1'b1, -1, 0);
            end
            hold(1'b1, $urandom_range(0, 12));
        end
        hold(1'b1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
